// File: rtl/vga_pkg.sv
// Shared VGA definitions: standard 640x480@60 timing constants, the
// {active, hs, vs} timing bundle and the colour-bar index helper.
package vga_pkg;

  // 640x480@60 (25.175 MHz pixel clock) timing.
  localparam int unsigned VGA_TOTAL_COLS  = 800;
  localparam int unsigned VGA_TOTAL_ROWS  = 525;
  localparam int unsigned VGA_ACTIVE_COLS = 640;
  localparam int unsigned VGA_ACTIVE_ROWS = 480;
  localparam int unsigned VGA_H_FP        = 16;
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_V_FP        = 10;
  localparam int unsigned VGA_V_SYNC      = 2;

  // Raw (polarity-free) timing decode carried down the delay line.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } timing_t;

  localparam int unsigned TIMING_W = $bits(timing_t);

  // Eight equal-width vertical bars across the visible line.
  function automatic logic [2:0] bar_index(input int unsigned col,
                                           input int unsigned active_cols);
    return 3'(col / (active_cols / 8));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with clock enable and synchronous reset value.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset; all stages load RST_VAL
//   ce    - shift enable
//   d     - data into stage 0
//   q     - last stage (DEPTH enabled shifts after d)
module vga_delay_line #(
  parameter int unsigned      WIDTH   = 1,
  parameter int unsigned      DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] din;

    if (g == 0) begin : g_head
      assign din = d;
    end else begin : g_tail
      assign din = g_stage[g-1].r;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r <= RST_VAL;
      end else if (ce) begin
        r <= din;
      end
    end
  end

  assign q = g_stage[DEPTH-1].r;

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator with pipeline alignment and RGB blanking.
// Optional feature macro: VGA_TEST_PATTERN_EN (adds i_test_mode and an
// 8-bar colour pattern that replaces game RGB while i_test_mode=1).
// Ports:
//   clk, i_rst_n                 - clock, synchronous active-low reset
//   i_pix_ce                     - pixel enable; all state advances only when high
//   i_r_val/i_g_val/i_b_val      - game RGB, presented PIPE_DELAY enables after
//                                  the counters show the matching pixel
//   o_col_counter/o_row_counter  - stage-0 pixel position
//   o_frame_start                - combinational: counters at (0,0) and i_pix_ce
//   o_hsync/o_vsync/o_active     - timing delayed PIPE_DELAY+1 enables, polarity applied
//   o_r_val/o_g_val/o_b_val      - RGB, forced to 0 outside the active area
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int unsigned VIDEO_WIDTH     = 3,
  parameter int unsigned TOTAL_COLS      = VGA_TOTAL_COLS,
  parameter int unsigned TOTAL_ROWS      = VGA_TOTAL_ROWS,
  parameter int unsigned ACTIVE_COLS     = VGA_ACTIVE_COLS,
  parameter int unsigned ACTIVE_ROWS     = VGA_ACTIVE_ROWS,
  parameter int unsigned H_FP            = VGA_H_FP,
  parameter int unsigned H_SYNC          = VGA_H_SYNC,
  parameter int unsigned V_FP            = VGA_V_FP,
  parameter int unsigned V_SYNC          = VGA_V_SYNC,
  parameter int unsigned SYNC_ACTIVE_LOW = 1,
  parameter int unsigned PIPE_DELAY      = 2,
  parameter int unsigned COUNT_W         = 10
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_pix_ce,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                   i_test_mode,
`endif
  input  logic [VIDEO_WIDTH-1:0] i_r_val,
  input  logic [VIDEO_WIDTH-1:0] i_g_val,
  input  logic [VIDEO_WIDTH-1:0] i_b_val,
  output logic [COUNT_W-1:0]     o_col_counter,
  output logic [COUNT_W-1:0]     o_row_counter,
  output logic                   o_frame_start,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_active,
  output logic [VIDEO_WIDTH-1:0] o_r_val,
  output logic [VIDEO_WIDTH-1:0] o_g_val,
  output logic [VIDEO_WIDTH-1:0] o_b_val
);

  localparam int unsigned H_SS  = ACTIVE_COLS + H_FP;
  localparam int unsigned H_SE  = H_SS + H_SYNC;
  localparam int unsigned V_SS  = ACTIVE_ROWS + V_FP;
  localparam int unsigned V_SE  = V_SS + V_SYNC;
  localparam int unsigned RGB_W = 3 * VIDEO_WIDTH;
  localparam logic SYNC_IDLE    = (SYNC_ACTIVE_LOW != 0);

  // Elaboration-time parameter sanity.
  if (H_SE > TOTAL_COLS) begin : g_chk_h
    $error("horizontal active+porch+sync exceeds TOTAL_COLS");
  end
  if (V_SE > TOTAL_ROWS) begin : g_chk_v
    $error("vertical active+porch+sync exceeds TOTAL_ROWS");
  end
  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_chk_d
    $error("PIPE_DELAY must be in 1..8");
  end
  if ((64'd1 << COUNT_W) < 64'(TOTAL_COLS) || (64'd1 << COUNT_W) < 64'(TOTAL_ROWS)) begin : g_chk_w
    $error("COUNT_W too narrow for TOTAL_COLS/TOTAL_ROWS");
  end

  logic [COUNT_W-1:0] col;
  logic [COUNT_W-1:0] row;
  logic               col_last;
  logic               row_last;

  assign col_last = (32'(col) == TOTAL_COLS - 1);
  assign row_last = (32'(row) == TOTAL_ROWS - 1);

  // Stage-0 pixel position.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (i_pix_ce) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + COUNT_W'(1);
      end else begin
        col <= col + COUNT_W'(1);
      end
    end
  end

  assign o_col_counter = col;
  assign o_row_counter = row;
  assign o_frame_start = i_rst_n & i_pix_ce & (col == '0) & (row == '0);

  // Raw decode of the stage-0 position; back porch is whatever is left.
  timing_t raw;
  timing_t tq;

  assign raw.active = (32'(col) < ACTIVE_COLS) && (32'(row) < ACTIVE_ROWS);
  assign raw.hs     = (32'(col) >= H_SS) && (32'(col) < H_SE);
  assign raw.vs     = (32'(row) >= V_SS) && (32'(row) < V_SE);

  vga_delay_line #(
    .WIDTH   (TIMING_W),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ('0)
  ) u_timing_dly (
    .clk   (clk),
    .rst_n (i_rst_n),
    .ce    (i_pix_ce),
    .d     (raw),
    .q     (tq)
  );

  logic [RGB_W-1:0] src_rgb;

`ifdef VGA_TEST_PATTERN_EN
  if (ACTIVE_COLS < 8) begin : g_chk_bar
    $error("ACTIVE_COLS must be at least 8 for the bar pattern");
  end

  logic [2:0]       bar;
  logic [RGB_W-1:0] pat_raw;
  logic [RGB_W-1:0] pat_q;

  // Pattern follows the same PIPE_DELAY path as game RGB so both align.
  assign bar     = bar_index(32'(col), ACTIVE_COLS);
  assign pat_raw = {{VIDEO_WIDTH{bar[2]}}, {VIDEO_WIDTH{bar[1]}}, {VIDEO_WIDTH{bar[0]}}};

  vga_delay_line #(
    .WIDTH   (RGB_W),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL ('0)
  ) u_pattern_dly (
    .clk   (clk),
    .rst_n (i_rst_n),
    .ce    (i_pix_ce),
    .d     (pat_raw),
    .q     (pat_q)
  );

  assign src_rgb = i_test_mode ? pat_q : {i_r_val, i_g_val, i_b_val};
`else
  assign src_rgb = {i_r_val, i_g_val, i_b_val};
`endif

  // Output stage: timing and blanked RGB leave on the same enabled edge.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_active <= 1'b0;
      o_hsync  <= SYNC_IDLE;
      o_vsync  <= SYNC_IDLE;
      o_r_val  <= '0;
      o_g_val  <= '0;
      o_b_val  <= '0;
    end else if (i_pix_ce) begin
      o_active <= tq.active;
      o_hsync  <= tq.hs ^ SYNC_IDLE;
      o_vsync  <= tq.vs ^ SYNC_IDLE;
      o_r_val  <= tq.active ? src_rgb[RGB_W-1 -: VIDEO_WIDTH]             : '0;
      o_g_val  <= tq.active ? src_rgb[2*VIDEO_WIDTH-1 -: VIDEO_WIDTH]     : '0;
      o_b_val  <= tq.active ? src_rgb[VIDEO_WIDTH-1 -: VIDEO_WIDTH]       : '0;
    end
  end

endmodule
